// File: rtl/rnd_seq_if.sv
// Handshake bundle between the hash round sequencer and its controller.
// The stall signal exists only when RND_STALL_EN is defined.
interface rnd_seq_if #(
    parameter int CNT_W = 6
);
    logic             start_rnd;
    logic [CNT_W-1:0] rounds_cfg;
    logic             abort;
`ifdef RND_STALL_EN
    logic             stall;
`endif
    logic             x_init;
    logic             co_init;
    logic             x_en;
    logic             co_en;
    logic [CNT_W-1:0] rnd_idx;
    logic             last_rnd;
    logic             busy;
    logic             done_rnd;
    logic             done_pulse;

    modport master (
`ifdef RND_STALL_EN
        output stall,
`endif
        output start_rnd, rounds_cfg, abort,
        input  x_init, co_init, x_en, co_en,
        input  rnd_idx, last_rnd, busy,
        input  done_rnd, done_pulse
    );

    modport slave (
`ifdef RND_STALL_EN
        input  stall,
`endif
        input  start_rnd, rounds_cfg, abort,
        output x_init, co_init, x_en, co_en,
        output rnd_idx, last_rnd, busy,
        output done_rnd, done_pulse
    );
endinterface

// File: rtl/rnd_seq_controller.sv
// Round sequencer: IDLE -> INIT -> RUN (N rounds) -> DONE -> IDLE.
// Optional RND_STALL_EN adds a stall input that freezes RUN progress.
module rnd_seq_controller #(
    parameter int ROUNDS = 64
) (
    input logic     clk,
    input logic     rst_n,
    rnd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             stall_w;
    logic             run_w;
    logic             at_last;

`ifdef RND_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_MAX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign at_last = (cnt_q == last_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start_rnd && !bus.abort) begin
                    state_d = S_INIT;
                    // last_q holds N-1 so a zero config maps to ROUNDS
                    if (bus.rounds_cfg == '0) begin
                        last_d = LAST_MAX;
                    end else begin
                        last_d = bus.rounds_cfg - 1'b1;
                    end
                end
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = bus.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!stall_w) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign run_w          = (state_q == S_RUN);
    assign bus.x_init     = (state_q == S_INIT);
    assign bus.co_init    = (state_q == S_INIT);
    assign bus.x_en       = run_w && !stall_w;
    assign bus.co_en      = run_w && !stall_w;
    assign bus.rnd_idx    = cnt_q;
    assign bus.last_rnd   = run_w && at_last;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done_rnd   = (state_q == S_IDLE);
    assign bus.done_pulse = (state_q == S_DONE);
endmodule

// File: tb/tb_rnd_seq_controller.sv
// Self-checking bench for rnd_seq_controller (ROUNDS=64).
// Run table plus hand sequences for reset, back-to-back and idle abort.
module tb_rnd_seq_controller;
    localparam int ROUNDS = 64;
    localparam int CW     = 6;

    typedef struct {
        int cfg;
        int abort_s;
        int stall_s;
        int stall_len;
        bit hold;
        int cfg_mid;
        int ens;
        int lasts;
        int pulses;
        int idle_at;
    } vec_t;

    typedef struct {
        int ens;
        int lasts;
        int pulses;
        int inits;
        int idle_at;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_pass;
    vec_t tbl[$];
    exp_t sb[$];

    rnd_seq_if #(.CNT_W(CW)) bus ();

    rnd_seq_controller #(.ROUNDS(ROUNDS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        logic [12:0] v;
        v = {bus.x_init, bus.co_init, bus.x_en, bus.co_en,
             bus.rnd_idx, bus.last_rnd, bus.busy,
             bus.done_rnd, bus.done_pulse};
        return int'(v);
    endfunction

    function automatic vec_t mk(
        input int cfg, input int ab, input int st, input int sl,
        input bit hold, input int cm, input int ens,
        input int lasts, input int pulses, input int idle_at
    );
        vec_t v;
        v.cfg = cfg;
        v.abort_s = ab;
        v.stall_s = st;
        v.stall_len = sl;
        v.hold = hold;
        v.cfg_mid = cm;
        v.ens = ens;
        v.lasts = lasts;
        v.pulses = pulses;
        v.idle_at = idle_at;
        return v;
    endfunction

    task automatic drive_idle();
        bus.start_rnd = 1'b0;
        bus.abort = 1'b0;
`ifdef RND_STALL_EN
        bus.stall = 1'b0;
`endif
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t a;
        int   mirr;
        int   s;
        logic [CW-1:0] c;
        e.ens = v.ens;
        e.lasts = v.lasts;
        e.pulses = v.pulses;
        e.inits = 1;
        e.idle_at = v.idle_at;
        sb.push_back(e);
        a = '{default: 0};
        mirr = 0;
        @(negedge clk);
        c = CW'(v.cfg);
        bus.rounds_cfg = c;
        bus.start_rnd = 1'b1;
        bus.abort = 1'b0;
        for (s = 1; s <= 200; s++) begin
            @(negedge clk);
            bus.start_rnd = v.hold;
            bus.abort = (s == v.abort_s);
`ifdef RND_STALL_EN
            bus.stall = (s >= v.stall_s) &&
                        (s < v.stall_s + v.stall_len);
`endif
            if (s == 3) begin
                c = CW'(v.cfg_mid);
                bus.rounds_cfg = c;
            end
            #1;
            if (bus.co_en !== bus.x_en) mirr++;
            if (bus.co_init !== bus.x_init) mirr++;
            if (bus.busy === bus.done_rnd) mirr++;
            if (bus.x_en === 1'b1) begin
                chk("rnd_idx", int'(bus.rnd_idx), a.ens);
                a.ens++;
            end
            if (bus.last_rnd === 1'b1) a.lasts++;
            if (bus.done_pulse === 1'b1) a.pulses++;
            if (bus.x_init === 1'b1) a.inits++;
            if (bus.done_rnd === 1'b1) begin
                a.idle_at = s;
                drive_idle();
                break;
            end
        end
        if (a.idle_at == 0) drive_idle();
        e = sb.pop_front();
        chk("x_en_count", a.ens, e.ens);
        chk("last_count", a.lasts, e.lasts);
        chk("pulse_count", a.pulses, e.pulses);
        chk("init_count", a.inits, e.inits);
        chk("idle_cycle", a.idle_at, e.idle_at);
        chk("mirror_out", mirr, 0);
    endtask

    initial begin
        n_tot = 0;
        n_pass = 0;
        rst_n = 1'b1;
        bus.rounds_cfg = '0;
        drive_idle();
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outs", outs(), 13'h0002);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(0, -1, 0, 0, 0, 0, 64, 1, 1, 67));
        tbl.push_back(mk(1, -1, 0, 0, 0, 1, 1, 1, 1, 4));
        tbl.push_back(mk(5, -1, 0, 0, 0, 5, 5, 1, 1, 8));
        tbl.push_back(mk(20, 12, 0, 0, 0, 20, 11, 0, 0, 13));
        tbl.push_back(mk(3, -1, 0, 0, 1, 7, 3, 1, 1, 6));
        tbl.push_back(mk(2, 4, 0, 0, 0, 2, 2, 1, 1, 5));
        tbl.push_back(mk(63, -1, 0, 0, 0, 63, 63, 1, 1, 66));
        tbl.push_back(mk(9, 1, 0, 0, 0, 9, 0, 0, 0, 2));
`ifdef RND_STALL_EN
        tbl.push_back(mk(8, -1, 6, 3, 0, 8, 8, 1, 1, 14));
        tbl.push_back(mk(8, 7, 6, 3, 0, 8, 4, 0, 0, 8));
`endif
        foreach (tbl[i]) run_vec(tbl[i]);

        // start held high: period N+3 with one IDLE cycle
        @(negedge clk);
        bus.rounds_cfg = 6'd2;
        bus.start_rnd = 1'b1;
        for (int s = 1; s <= 15; s++) begin
            @(negedge clk);
            #1;
            chk("b2b_done", int'(bus.done_rnd), int'(s % 5 == 0));
            chk("b2b_init", int'(bus.x_init), int'(s % 5 == 1));
        end
        drive_idle();

        // start together with abort in IDLE
        @(negedge clk);
        bus.start_rnd = 1'b1;
        bus.abort = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            #1;
            chk("idle_abort", outs(), 13'h0002);
        end
        drive_idle();

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bus.rounds_cfg = '0;
        bus.start_rnd = 1'b1;
        @(negedge clk);
        bus.start_rnd = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre_rst_busy", int'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), 13'h0002);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst", outs(), 13'h0002);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
